// File: rtl/disp_pkg.sv
// Shared constants, types and helpers for the multiplexed 7-segment scan decoder.
// DISP layout: [11:8] active-low anodes, [7] active-low dp, [6:0] active-low segments g..a.
package disp_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DISP_W     = 12;
  localparam int unsigned ANODE_MSB  = 11;
  localparam int unsigned ANODE_LSB  = 8;
  localparam int unsigned DP_BIT     = 7;
  localparam int unsigned SEG_MSB    = 6;
  localparam int unsigned SEG_LSB    = 0;

  // Active-low codes {dp,g,f,e,d,c,b,a} with dp off; entry index is the hex nibble shown.
  localparam logic [15:0][7:0] GLYPH_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } scan_state_e;

  function automatic logic single_low(input logic [NUM_DIGITS-1:0] anodes);
    return $onehot(~anodes);
  endfunction

  // Meaningful only when single_low() holds for the same anode vector.
  function automatic logic [1:0] low_index(input logic [NUM_DIGITS-1:0] anodes);
    logic [1:0] idx;
    idx = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (!anodes[k]) idx = 2'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/display_scan_decoder_glyph.sv
// seg7_glyph_decode: combinational lookup of 7 active-low segment bits into a hex nibble.
// valid is low for any pattern that is not one of the 16 hex glyphs.
module seg7_glyph_decode
  import disp_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       valid
);

  always_comb begin
    // NOTE: defaults come first so every path assigns the outputs and no latch is inferred.
    nibble = '0;
    valid  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg == GLYPH_TABLE[i][6:0]) begin
        nibble = 4'(i);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_scan_decoder.sv
// Recovers the 4-digit hex value shown on a scanned 7-segment display by sniffing its drive lines.
// Optional macro DISP_DP_CAPTURE_EN adds a per-digit decimal-point output `dp`.
module display_scan_decoder
  import disp_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned STALE_CYCLES  = 1048576
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [DISP_W-1:0]       DISP,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    frame_valid,
  output logic                    glyph_err,
  output logic                    stale
`ifdef DISP_DP_CAPTURE_EN
  ,
  output logic [NUM_DIGITS-1:0]   dp
`endif
);

  localparam logic [7:0]           SETTLE_LAST = 8'(SETTLE_CYCLES);
  localparam int unsigned          STALE_W     = $clog2(STALE_CYCLES + 1);
  localparam logic [STALE_W-1:0]   STALE_MAX   = STALE_W'(STALE_CYCLES);

  scan_state_e               state, state_next;
  logic [7:0]                cnt, cnt_next;
  logic [DISP_W-1:0]         disp_q, disp_prev;
  logic [4*NUM_DIGITS-1:0]   shadow, shadow_next;
  logic [NUM_DIGITS-1:0]     seen, seen_next;
  logic                      frame_err, err_next;
  logic [STALE_W-1:0]        stale_cnt;
  logic                      sample_ok, changed, capture;
  logic [1:0]                digit_idx;
  logic [3:0]                glyph_nibble;
  logic                      glyph_valid;

  assign sample_ok = single_low(disp_q[ANODE_MSB:ANODE_LSB]);
  assign changed   = (disp_q != disp_prev);
  assign digit_idx = low_index(disp_q[ANODE_MSB:ANODE_LSB]);

  seg7_glyph_decode u_glyph (
    .seg    (disp_q[SEG_MSB:SEG_LSB]),
    .nibble (glyph_nibble),
    .valid  (glyph_valid)
  );

  // State register.
  always_ff @(posedge CLK) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    if (!RST_N) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next state: a fresh one-hot sample restarts the count at 1; SETTLE_CYCLES=1 captures at once.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (sample_ok) begin
          state_next = (SETTLE_LAST == 8'd1) ? HELD : SETTLE;
          cnt_next   = 8'd1;
        end
      end
      SETTLE, HELD: begin
        if (changed) begin
          if (sample_ok) begin
            state_next = (SETTLE_LAST == 8'd1) ? HELD : SETTLE;
            cnt_next   = 8'd1;
          end else begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end else if (state == SETTLE) begin
          cnt_next = cnt + 8'd1;
          if (cnt_next == SETTLE_LAST) state_next = HELD;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Output decode: every entry into HELD is a capture of the current sample.
  always_comb begin
    capture = (state_next == HELD) && ((state != HELD) || changed);
  end

  always_comb begin
    shadow_next                           = shadow;
    seen_next                             = seen;
    shadow_next[{digit_idx, 2'b00} +: 4] = glyph_nibble;
    seen_next[digit_idx]                  = 1'b1;
    err_next                              = frame_err | ~glyph_valid;
  end

`ifdef DISP_DP_CAPTURE_EN
  logic [NUM_DIGITS-1:0] dp_shadow, dp_next;

  always_comb begin
    dp_next            = dp_shadow;
    dp_next[digit_idx] = ~disp_q[DP_BIT];
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      dp_shadow <= '0;
      dp        <= '0;
    end else if (capture) begin
      dp_shadow <= dp_next;
      if (seen_next == '1) dp <= dp_next;
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      disp_q      <= '0;
      disp_prev   <= '0;
      // NOTE: the shadow is ordinary flops, reset so a mid-frame reset drops partial captures.
      shadow      <= '0;
      seen        <= '0;
      frame_err   <= 1'b0;
      value       <= '0;
      frame_valid <= 1'b0;
      glyph_err   <= 1'b0;
      stale_cnt   <= '0;
    end else begin
      disp_q      <= DISP;
      disp_prev   <= disp_q;
      frame_valid <= 1'b0;
      if (stale_cnt != STALE_MAX) stale_cnt <= stale_cnt + 1'b1;
      if (capture) begin
        shadow <= shadow_next;
        if (seen_next == '1) begin
          value       <= shadow_next;
          glyph_err   <= err_next;
          frame_valid <= 1'b1;
          seen        <= '0;
          frame_err   <= 1'b0;
          stale_cnt   <= '0;
        end else begin
          seen      <= seen_next;
          frame_err <= err_next;
        end
      end
    end
  end

  assign stale = (stale_cnt == STALE_MAX);

endmodule
